// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: default widths, state encodings,
// and the layout of the decoded control bundle.
package id_ex_pkg;

  localparam int CTRL_W_DEF  = 14;
  localparam int DATA_W_DEF  = 192;
  localparam int NUM_OPS_DEF = 8;
  localparam int RR_W_DEF    = 4;

  // Occupancy states: no entry, main entry only, main plus skid entry.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  // Control bundle, MSB first; rsvd pads the bundle out to CTRL_W_DEF bits.
  typedef struct packed {
    logic       rsvd;
    logic       jump_i;
    logic       jump_ci;
    logic       jump_cd;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       vector_op;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic       alu_src3;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_perf_ctr.sv
// Saturating 32-bit event counter with an optional parallel load; updates on the
// falling edge to line up with the pipeline stage it observes.
module id_ex_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] count
);

  // Load wins over counting; the count sticks at all-ones instead of wrapping.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, two-entry skid buffer and flush.
// Optional performance counters are built when ID_EX_PERF_EN is defined.
module id_ex_pipe_stage
  import id_ex_pkg::*;
#(
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_OPS = NUM_OPS_DEF,
  parameter int RR_W    = RR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_OPS*DATA_W-1:0] in_data,
  input  logic [RR_W-1:0]           in_rr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_OPS*DATA_W-1:0] out_data,
  output logic [RR_W-1:0]           out_rr
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt
`endif
);

  logic [1:0]                state;
  logic [CTRL_W-1:0]         main_ctrl, skid_ctrl;
  logic [NUM_OPS*DATA_W-1:0] main_data, skid_data;
  logic [RR_W-1:0]           main_rr, skid_rr;

  logic accept, drain;
  logic load_main, load_skid, shift_skid;

  // in_ready depends on the state register only, so out_ready never reaches it.
  assign in_ready  = (state != S_TWO);
  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  assign load_main  = accept && ((state == S_EMPTY) || ((state == S_ONE) && drain));
  assign load_skid  = accept && (state == S_ONE) && !drain;
  assign shift_skid = drain && (state == S_TWO);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state <= S_ONE;
        S_ONE: begin
          if (accept && !drain) state <= S_TWO;
          else if (!accept && drain) state <= S_EMPTY;
        end
        S_TWO:   if (drain) state <= S_ONE;
        default: state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      main_rr   <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      skid_rr   <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      main_data <= '0;
      main_rr   <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      skid_rr   <= '0;
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
        main_rr   <= in_rr;
      end else if (shift_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        main_rr   <= skid_rr;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
        skid_rr   <= in_rr;
      end
    end
  end

  // A drained main entry keeps its old contents, so gate outputs into a zero bubble.
  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = out_valid ? main_data : '0;
  assign out_rr   = out_valid ? main_rr   : '0;

`ifdef ID_EX_PERF_EN
  id_ex_perf_ctr u_stall_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (in_valid && !in_ready),
    .load     (1'b0),
    .load_val (32'd0),
    .count    (stall_cnt)
  );

  id_ex_perf_ctr u_bubble_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (out_ready && !out_valid),
    .load     (1'b0),
    .load_val (32'd0),
    .count    (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage; also covers the perf counters when
// ID_EX_PERF_EN is defined and the saturating counter on its own.
module tb_id_ex_pipe_stage;
  import id_ex_pkg::*;

  localparam int CW = 14;
  localparam int DW = 192;
  localparam int NO = 8;
  localparam int RW = 4;

  typedef struct packed {
    logic [CW-1:0]    ctrl;
    logic [NO*DW-1:0] data;
    logic [RW-1:0]    rr;
  } item_t;

  logic             clk = 1'b1;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_ctrl;
  logic [NO*DW-1:0] in_data;
  logic [RW-1:0]    in_rr;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_ctrl;
  logic [NO*DW-1:0] out_data;
  logic [RW-1:0]    out_rr;
`ifdef ID_EX_PERF_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      bubble_cnt;
`endif

  logic        sat_en, sat_load;
  logic [31:0] sat_val, sat_count;

  item_t q[$];
  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .NUM_OPS(NO), .RR_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_rr     (in_rr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_rr    (out_rr)
`ifdef ID_EX_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  id_ex_perf_ctr u_sat (
    .clk      (clk),
    .rst      (rst),
    .en       (sat_en),
    .load     (sat_load),
    .load_val (sat_val),
    .count    (sat_count)
  );

  // One cycle: drive inputs, check outputs against the scoreboard, update model, take edge.
  task automatic step(input logic v, input logic [RW-1:0] rr, input logic ordy, input logic fl);
    item_t it, exp;
    logic exp_ready, exp_valid;
    id_ex_ctrl_t c;
    c = id_ex_ctrl_t'($urandom());
    c.rsvd = 1'b0;
    it.ctrl = c;
    for (int k = 0; k < (NO * DW) / 32; k++) it.data[k*32 +: 32] = $urandom();
    it.rr = rr;
    in_valid = v; in_ctrl = it.ctrl; in_data = it.data; in_rr = it.rr;
    out_ready = ordy; flush = fl;
    #1;
    exp_ready = (q.size() < 2);
    exp_valid = (q.size() != 0);
    exp = exp_valid ? q[0] : '0;
    tests_run++;
    if (in_ready !== exp_ready) begin
      failures++;
      $display("[TB] FAIL sb_in_ready: got %b expected %b", in_ready, exp_ready);
    end
    tests_run++;
    if (out_valid !== exp_valid) begin
      failures++;
      $display("[TB] FAIL sb_out_valid: got %b expected %b", out_valid, exp_valid);
    end
    tests_run++;
    if ({out_ctrl, out_data, out_rr} !== exp) begin
      failures++;
      $display("[TB] FAIL sb_entry: got rr=%0d ctrl=%h data_lo=%h expected rr=%0d ctrl=%h data_lo=%h",
               out_rr, out_ctrl, out_data[63:0], exp.rr, exp.ctrl, exp.data[63:0]);
    end
    if (fl) begin
      q.delete();
    end else begin
      if (exp_valid && ordy) void'(q.pop_front());
      if (v && exp_ready) q.push_back(it);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0; in_rr = '0;
    sat_en = 1'b0; sat_load = 1'b0; sat_val = '0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_handshake: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    tests_run++;
    if (out_ctrl !== '0 || out_data !== '0 || out_rr !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got rr=%0d ctrl=%h expected all zero", out_rr, out_ctrl);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_streaming;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, RW'(i), 1'b1, 1'b0);
      tests_run++;
      if (out_valid !== 1'b1 || out_rr !== RW'(i) || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_latency: got valid=%b rr=%0d ready=%b expected valid=1 rr=%0d ready=1",
                 out_valid, out_rr, in_ready, i);
      end
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_stall;
    step(1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd6, 1'b0, 1'b0);
    tests_run++;
    if (in_ready !== 1'b0 || out_rr !== 4'd5) begin
      failures++;
      $display("[TB] FAIL stall_full: got ready=%b rr=%0d expected ready=0 rr=5", in_ready, out_rr);
    end
    step(1'b1, 4'd7, 1'b0, 1'b0);
    step(1'b1, 4'd7, 1'b1, 1'b0);
    tests_run++;
    if (out_rr !== 4'd6 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release: got rr=%0d ready=%b expected rr=6 ready=1", out_rr, in_ready);
    end
    step(1'b1, 4'd7, 1'b1, 1'b0);
    tests_run++;
    if (out_rr !== 4'd7) begin
      failures++;
      $display("[TB] FAIL stall_order: got rr=%0d expected 7", out_rr);
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_two;
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b1, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || out_rr !== '0 || out_ctrl !== '0 || out_data !== '0) begin
      failures++;
      $display("[TB] FAIL flush_two: got valid=%b rr=%0d ctrl=%h expected all zero", out_valid, out_rr, out_ctrl);
    end
    // Flush in ONE where an accept and a drain would otherwise both happen.
    step(1'b1, 4'd11, 1'b0, 1'b0);
    step(1'b1, 4'd12, 1'b1, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || out_rr !== '0) begin
      failures++;
      $display("[TB] FAIL flush_one: got valid=%b rr=%0d expected valid=0 rr=0", out_valid, out_rr);
    end
    step(1'b1, 4'd9, 1'b0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_rr !== 4'd9) begin
      failures++;
      $display("[TB] FAIL flush_next: got valid=%b rr=%0d expected valid=1 rr=9", out_valid, out_rr);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_alone: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_flush_empty;
    step(1'b1, 4'd3, 1'b0, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rr !== '0) begin
      failures++;
      $display("[TB] FAIL flush_empty: got valid=%b ready=%b rr=%0d expected valid=0 ready=1 rr=0",
               out_valid, in_ready, out_rr);
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    step(1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b1, 4'd8, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rr !== '0 || out_ctrl !== '0 || out_data !== '0) begin
      failures++;
      $display("[TB] FAIL reset_async: got valid=%b ready=%b rr=%0d expected valid=0 ready=1 rr=0",
               out_valid, in_ready, out_rr);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    q.delete();
    tests_run++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
      failures++;
      $display("[TB] FAIL perf_reset: got stall=%0d bubble=%0d expected 0 0", stall_cnt, bubble_cnt);
    end
    @(negedge clk);
    #1;
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'd3, 1'b0, 1'b0);
    tests_run++;
    if (stall_cnt !== 32'd4 || bubble_cnt !== 32'd2) begin
      failures++;
      $display("[TB] FAIL perf_counts: got stall=%0d bubble=%0d expected 4 2", stall_cnt, bubble_cnt);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (stall_cnt !== 32'd4 || bubble_cnt !== 32'd2) begin
      failures++;
      $display("[TB] FAIL perf_flush: got stall=%0d bubble=%0d expected 4 2", stall_cnt, bubble_cnt);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (bubble_cnt !== 32'd3) begin
      failures++;
      $display("[TB] FAIL perf_bubble: got %0d expected 3", bubble_cnt);
    end
  endtask
`endif

  task automatic test_saturation;
    tests_run++;
    if (sat_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL sat_idle: got %h expected 0", sat_count);
    end
    sat_load = 1'b1; sat_val = 32'hFFFF_FFFE; sat_en = 1'b0;
    @(negedge clk);
    #1;
    sat_load = 1'b0;
    tests_run++;
    if (sat_count !== 32'hFFFF_FFFE) begin
      failures++;
      $display("[TB] FAIL sat_load: got %h expected fffffffe", sat_count);
    end
    sat_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (sat_count !== 32'hFFFF_FFFF) begin
        failures++;
        $display("[TB] FAIL sat_hold: got %h expected ffffffff after event %0d", sat_count, i + 1);
      end
    end
    sat_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush_two();
    test_flush_empty();
    test_reset_mid();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
